// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline stage.
package pipe_pkg;
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } stateT;

    localparam int DEF_DATA_W    = 64;
    localparam int DEF_CTRL_W    = 2;
    localparam int DEF_DEST_W    = 5;
    localparam int DEF_REG_IDX_W = 5;
endpackage

// File: rtl/pipe_reg_en.sv
// Width-parametrised load-enable register with async active-low clear to zero.
module pipe_reg_en #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready handshake, 2-entry skid buffer, flush.
// Optional saturating stall counter when PIPE_STAGE_STALL_CNT_EN is defined.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int DEST_W = DEF_DEST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [DEST_W-1:0] out_dest
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);
    localparam int BEAT_W = CTRL_W + DATA_W + DEST_W;

    stateT             state, nextState;
    logic              inReadyQ;
    logic              accept, issue;
    logic              mainLoad, skidLoad;
    logic [BEAT_W-1:0] inBeat, mainD, mainQ, skidQ;
    logic [CTRL_W-1:0] mainCtrl;

    assign accept = in_valid & inReadyQ;
    assign issue  = out_valid & out_ready;
    assign inBeat = {in_ctrl, in_data, in_dest};

    always_comb begin
        nextState = state;
        case (state)
            EMPTY:   if (accept) nextState = ONE;
            ONE: begin
                if (accept && !issue)      nextState = TWO;
                else if (!accept && issue) nextState = EMPTY;
            end
            TWO:     if (issue) nextState = ONE;
            default: nextState = EMPTY;
        endcase
    end

    // in_ready comes straight from a flop so out_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= EMPTY;
            inReadyQ <= 1'b1;
        end else if (flush) begin
            state    <= EMPTY;
            inReadyQ <= 1'b1;
        end else begin
            state    <= nextState;
            inReadyQ <= (nextState != TWO);
        end
    end

    // Main refills from skid when draining TWO, otherwise from the input.
    assign mainLoad = !flush && ((state == EMPTY && accept) ||
                                 (state == ONE && accept && issue) ||
                                 (state == TWO && issue));
    assign skidLoad = !flush && state == ONE && accept && !issue;
    assign mainD    = (state == TWO) ? skidQ : inBeat;

    pipe_reg_en #(.W(BEAT_W)) uMain (
        .clk(clk), .rst(rst), .en(mainLoad), .d(mainD), .q(mainQ)
    );

    pipe_reg_en #(.W(BEAT_W)) uSkid (
        .clk(clk), .rst(rst), .en(skidLoad), .d(inBeat), .q(skidQ)
    );

    assign mainCtrl  = mainQ[BEAT_W-1 -: CTRL_W];
    assign out_valid = (state != EMPTY);
    assign in_ready  = inReadyQ;
    assign out_ctrl  = out_valid ? mainCtrl : '0;
    assign out_data  = mainQ[DEST_W +: DATA_W];
    assign out_dest  = mainQ[DEST_W-1:0];

`ifdef PIPE_STAGE_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, elastic successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control field, a data payload and a destination-register index across one stage boundary.
- Adds a valid/ready handshake, a 2-entry skid buffer so stalls never drop data, and a synchronous flush that inserts bubbles.
- Control bits are forced to zero on bubbles, so a flushed or empty slot can never assert RegWrite or MemToReg downstream.

Parameters:
- DATA_W, 64: payload width in bits (e.g. ReadData concatenated with ALUResult).
- CTRL_W, 2: control-bit width (e.g. MemToReg, RegWrite).
- DEST_W, 5: destination register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- flush  in  1  synchronous flush; highest priority.
- in_valid  in  1  upstream presents a beat.
- in_ready  out  1  stage can accept a beat; registered.
- in_ctrl  in  CTRL_W  upstream control bits.
- in_data  in  DATA_W  upstream payload.
- in_dest  in  DEST_W  upstream destination index.
- out_valid  out  1  stage presents a beat downstream.
- out_ready  in  1  downstream accepts the beat.
- out_ctrl  out  CTRL_W  control bits; forced to 0 whenever out_valid=0.
- out_data  out  DATA_W  payload.
- out_dest  out  DEST_W  destination index.

Behaviour:
- Storage: a main entry (drives outputs) and a skid entry. Handshakes are counted per edge: accept = in_valid & in_ready; issue = out_valid & out_ready.
- State machine:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main valid; out_valid=1, in_ready=1.
  - TWO: main and skid valid; out_valid=1, in_ready=0.
- Transitions:
  - EMPTY: accept -> load main, go to ONE.
  - ONE: accept & issue -> main <= input, stay in ONE. Issue only -> EMPTY. Accept only -> skid <= input, go to TWO. Neither -> hold.
  - TWO: issue -> main <= skid, go to ONE. Otherwise hold. No accept is possible in TWO.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 beat per cycle while out_ready=1.
- Ordering: strictly FIFO. No beat is duplicated or dropped, except by flush.
- flush=1 at an edge:
  - State goes to EMPTY; both entries are invalidated.
  - Any beat accepted in the same cycle is discarded.
  - An issue in the same cycle still counts as delivered downstream.
  - in_ready=1 on the following cycle.
- Reset (rst=0, async, any time including mid-stall):
  - State EMPTY; out_valid=0; in_ready=1.
  - out_ctrl, out_data and out_dest are all 0; the skid entry is cleared to 0.
  - Release is synchronised by the system; the block itself requires no release sequencing.
- Bubble values: when out_valid=0, out_ctrl=0 combinationally. out_data and out_dest hold their last values and carry no meaning.
- in_ready is a register output. There is no combinational path from out_ready to in_ready.
- Widths: all fields are stored verbatim; no arithmetic is performed on the datapath.

Optional Feature:
- Macro: PIPE_STAGE_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [31:0].
  - Increments on every cycle with out_valid=1 and out_ready=0; saturates at 32'hFFFF_FFFF.
  - Cleared to 0 by reset only; flush does not clear it.
- When undefined: the port and counter are absent, and the block is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - State typedef with encodings EMPTY=2'b00, ONE=2'b01, TWO=2'b10.
  - Default width constants (DATA_W 64, CTRL_W 2, DEST_W 5, REG_IDX_W 5).
- One sub-module, pipe_reg_en: a width-parametrised register with async active-low reset to 0 and a load enable. It is instantiated for the main and skid entries.

Test Plan:
- Reset then stream: rst low 3 cycles, then 4 beats data=0x11..0x44, ctrl=2'b10, out_ready=1 -> outputs appear 1 cycle after each accept in order; in_ready stays 1.
- Backpressure: beats A=0xA, B=0xB back-to-back, out_ready=0 from A's issue cycle -> state TWO, in_ready=0; on release, A then B issue on consecutive cycles, no loss.
- Flush in TWO with in_valid=1, data=0xC -> next cycle out_valid=0, out_ctrl=2'b00, in_ready=1; 0xA, 0xB and 0xC never appear.
- Bubble control: in_valid=0 with in_ctrl=2'b11 held -> out_ctrl stays 2'b00 throughout.
- Async reset mid-stall: rst low between clock edges while in TWO -> out_valid=0 and all outputs 0 immediately, before the next edge.
- With PIPE_STAGE_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 7 cycles -> stall_cnt=7; a flush leaves stall_cnt at 7.
